// File: rtl/branch_pkg.sv
// Shared types and constants for the branch predictor update-side controller.
package branch_pkg;

  localparam int unsigned PC_WIDTH = 32;

  // One in-flight prediction: the branch PC and the direction the predictor gave.
  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic                pred;
  } inflight_entry_t;

endpackage

// File: rtl/branch_inflight_fifo.sv
// In-order queue of issued predictions awaiting resolution.
// Storage is indexed by wrapping pointers; occupancy is kept in its own
// counter so full and empty never need pointer comparison.
module branch_inflight_fifo
  import branch_pkg::*;
#(
  parameter int unsigned p_depth = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_val,
  output logic                     in_rdy,
  input  inflight_entry_t          in_data,
  output logic                     out_val,
  input  logic                     out_rdy,
  output inflight_entry_t          out_data,
  output logic [$clog2(p_depth):0] occupancy
);

  localparam int unsigned PTR_W = $clog2(p_depth);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(p_depth);
  localparam logic [OCC_W-1:0] OCC_EMPTY = {OCC_W{1'b0}};
  localparam logic [OCC_W-1:0] OCC_ONE   = OCC_W'(1'b1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1'b1);

  inflight_entry_t  mem_q [p_depth];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             push_s;
  logic             pop_s;

  // No bypass: a full queue refuses a push even if a pop happens this cycle,
  // and a freshly pushed entry is not visible at the head until next cycle.
  assign in_rdy    = (occ_q != OCC_FULL);
  assign out_val   = (occ_q != OCC_EMPTY);
  assign push_s    = in_val && in_rdy;
  assign pop_s     = out_val && out_rdy;
  assign out_data  = mem_q[rd_ptr_q];
  assign occupancy = occ_q;

  // Next-state for pointers (wrap naturally, depth is a power of two) and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   occ_d = occ_q + OCC_ONE;
      2'b01:   occ_d = occ_q - OCC_ONE;
      default: occ_d = occ_q;
    endcase
  end

  // Entry storage; writes are suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (reset && push_s) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  // Pointer and occupancy registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      occ_q    <= OCC_EMPTY;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

endmodule

// File: rtl/branch_update_ctrl.sv
// Update-side controller for the global branch predictor: forwards the fetch
// PC to the predictor, queues each prediction, and on resolution drives a
// registered update strobe, a mispredict pulse and saturating accuracy counters.
module branch_update_ctrl
  import branch_pkg::*;
#(
  parameter int unsigned p_depth     = 4,
  parameter int unsigned p_cnt_width = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetch_val,
  output logic                     fetch_rdy,
  input  logic [PC_WIDTH-1:0]      fetch_pc,
  output logic [PC_WIDTH-1:0]      pred_pc,
  input  logic                     pred_in,
  output logic                     fetch_pred,
  input  logic                     resolve_val,
  output logic                     resolve_rdy,
  input  logic                     resolve_taken,
  output logic [PC_WIDTH-1:0]      resolve_pc,
  output logic                     update_en,
  output logic                     update_val,
  output logic                     mispredict,
  output logic [$clog2(p_depth):0] occupancy,
  output logic [p_cnt_width-1:0]   total_cnt,
  output logic [p_cnt_width-1:0]   mispred_cnt
);

  localparam logic [p_cnt_width-1:0] CNT_MAX  = {p_cnt_width{1'b1}};
  localparam logic [p_cnt_width-1:0] CNT_ZERO = {p_cnt_width{1'b0}};
  localparam logic [p_cnt_width-1:0] CNT_ONE  = p_cnt_width'(1'b1);

  inflight_entry_t          push_entry_s;
  inflight_entry_t          head_s;
  logic                     pop_fire_s;
  logic                     mis_s;

  logic                     update_en_q, update_en_d;
  logic                     update_val_q, update_val_d;
  logic                     mispredict_q, mispredict_d;
  logic [p_cnt_width-1:0]   total_cnt_q, total_cnt_d;
  logic [p_cnt_width-1:0]   mispred_cnt_q, mispred_cnt_d;

  assign pred_pc           = fetch_pc;
  assign fetch_pred        = pred_in;
  assign push_entry_s.pc   = fetch_pc;
  assign push_entry_s.pred = pred_in;

  branch_inflight_fifo #(
    .p_depth (p_depth)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .in_val    (fetch_val),
    .in_rdy    (fetch_rdy),
    .in_data   (push_entry_s),
    .out_val   (resolve_rdy),
    .out_rdy   (resolve_val),
    .out_data  (head_s),
    .occupancy (occupancy)
  );

  assign resolve_pc = head_s.pc;
  assign pop_fire_s = resolve_val && resolve_rdy;
  assign mis_s      = head_s.pred ^ resolve_taken;

  // Next-state for the update stage and the saturating counters.
  always_comb begin
    update_en_d   = pop_fire_s;
    mispredict_d  = pop_fire_s && mis_s;
    update_val_d  = update_val_q;
    total_cnt_d   = total_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (pop_fire_s) begin
      update_val_d = resolve_taken;
      if (total_cnt_q != CNT_MAX) begin
        total_cnt_d = total_cnt_q + CNT_ONE;
      end else begin
        total_cnt_d = total_cnt_q;
      end
      if (mis_s && (mispred_cnt_q != CNT_MAX)) begin
        mispred_cnt_d = mispred_cnt_q + CNT_ONE;
      end else begin
        mispred_cnt_d = mispred_cnt_q;
      end
    end else begin
      update_val_d = update_val_q;
    end
  end

  // Update-stage and counter registers; reset wins over any same-cycle pop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      update_en_q   <= 1'b0;
      update_val_q  <= 1'b0;
      mispredict_q  <= 1'b0;
      total_cnt_q   <= CNT_ZERO;
      mispred_cnt_q <= CNT_ZERO;
    end else begin
      update_en_q   <= update_en_d;
      update_val_q  <= update_val_d;
      mispredict_q  <= mispredict_d;
      total_cnt_q   <= total_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign update_en   = update_en_q;
  assign update_val  = update_val_q;
  assign mispredict  = mispredict_q;
  assign total_cnt   = total_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_update_ctrl.sv
// Scoreboard bench for branch_update_ctrl (depth 4, 4-bit counters).
module tb_branch_update_ctrl;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_val, fetch_rdy, pred_in, fetch_pred;
  logic [31:0] fetch_pc, pred_pc, resolve_pc;
  logic        resolve_val, resolve_rdy, resolve_taken;
  logic        update_en, update_val, mispredict;
  logic [2:0]  occupancy;
  logic [CW-1:0] total_cnt, mispred_cnt;

  branch_update_ctrl #(.p_depth(DEPTH), .p_cnt_width(CW)) dut (
    .clk(clk), .reset(reset),
    .fetch_val(fetch_val), .fetch_rdy(fetch_rdy), .fetch_pc(fetch_pc),
    .pred_pc(pred_pc), .pred_in(pred_in), .fetch_pred(fetch_pred),
    .resolve_val(resolve_val), .resolve_rdy(resolve_rdy),
    .resolve_taken(resolve_taken), .resolve_pc(resolve_pc),
    .update_en(update_en), .update_val(update_val), .mispredict(mispredict),
    .occupancy(occupancy), .total_cnt(total_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic pred; } ent_t;
  typedef struct { logic uv; logic mp; logic [CW-1:0] tot; logic [CW-1:0] mis; } exp_t;

  ent_t mq[$];          // reference in-flight queue
  exp_t sb[$];          // expected update-stage responses
  logic [CW-1:0] exp_tot, exp_mis;
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every update strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (update_en === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_update: got update_en=1 expected no pending update at %0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_update_val", {31'd0, update_val}, {31'd0, e.uv});
        chk("sb_mispredict", {31'd0, mispredict}, {31'd0, e.mp});
        chk("sb_total_cnt", {28'd0, total_cnt}, {28'd0, e.tot});
        chk("sb_mispred_cnt", {28'd0, mispred_cnt}, {28'd0, e.mis});
      end
    end
  end

  // One clock of stimulus; called at posedge+1, returns at next posedge+1.
  task automatic step(input logic fv, input logic [31:0] pc, input logic pin,
                      input logic rv, input logic rt);
    int unsigned sz;
    ent_t h;
    exp_t e;
    sz = mq.size();
    fetch_val = fv; fetch_pc = pc; pred_in = pin;
    resolve_val = rv; resolve_taken = rt;
    #1;
    chk("fetch_rdy", {31'd0, fetch_rdy}, {31'd0, (sz != DEPTH)});
    chk("resolve_rdy", {31'd0, resolve_rdy}, {31'd0, (sz != 0)});
    chk("pred_pc", pred_pc, pc);
    chk("fetch_pred", {31'd0, fetch_pred}, {31'd0, pin});
    if (rv && sz != 0) begin
      h = mq.pop_front();
      chk("resolve_pc", resolve_pc, h.pc);
      if (exp_tot != 4'hF) exp_tot = exp_tot + 4'd1;
      if (h.pred != rt && exp_mis != 4'hF) exp_mis = exp_mis + 4'd1;
      e.uv = rt; e.mp = (h.pred != rt); e.tot = exp_tot; e.mis = exp_mis;
      sb.push_back(e);
    end
    if (fv && sz != DEPTH) begin
      h.pc = pc; h.pred = pin;
      mq.push_back(h);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0; fetch_val = 1'b1; resolve_val = 1'b1;
    fetch_pc = 32'h40; pred_in = 1'b1; resolve_taken = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b1; fetch_val = 1'b0; resolve_val = 1'b0;
    mq.delete();
    exp_tot = 4'd0; exp_mis = 4'd0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_occupancy"}, {29'd0, occupancy}, 32'd0);
    chk({tag, "_fetch_rdy"}, {31'd0, fetch_rdy}, 32'd1);
    chk({tag, "_resolve_rdy"}, {31'd0, resolve_rdy}, 32'd0);
    chk({tag, "_update_en"}, {31'd0, update_en}, 32'd0);
    chk({tag, "_update_val"}, {31'd0, update_val}, 32'd0);
    chk({tag, "_mispredict"}, {31'd0, mispredict}, 32'd0);
    chk({tag, "_total_cnt"}, {28'd0, total_cnt}, 32'd0);
    chk({tag, "_mispred_cnt"}, {28'd0, mispred_cnt}, 32'd0);
  endtask

  initial begin
    reset = 1'b0; fetch_val = 1'b0; fetch_pc = 32'h0; pred_in = 1'b0;
    resolve_val = 1'b0; resolve_taken = 1'b0;
    exp_tot = 4'd0; exp_mis = 4'd0;

    // Reset with both handshakes requested
    do_reset(2);
    chk_reset_state("rst");

    // Correct prediction
    step(1'b1, 32'h20C, 1'b0, 1'b0, 1'b0);
    chk("corr_occ", {29'd0, occupancy}, 32'd1);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("corr_update_en", {31'd0, update_en}, 32'd1);
    chk("corr_update_val", {31'd0, update_val}, 32'd0);
    chk("corr_mispredict", {31'd0, mispredict}, 32'd0);
    chk("corr_total", {28'd0, total_cnt}, 32'd1);
    chk("corr_mis", {28'd0, mispred_cnt}, 32'd0);
    idle();
    chk("corr_update_en_off", {31'd0, update_en}, 32'd0);

    // Mispredict
    step(1'b1, 32'h20C, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    chk("mis_update_en", {31'd0, update_en}, 32'd1);
    chk("mis_update_val", {31'd0, update_val}, 32'd1);
    chk("mis_mispredict", {31'd0, mispredict}, 32'd1);
    chk("mis_total", {28'd0, total_cnt}, 32'd2);
    chk("mis_mis", {28'd0, mispred_cnt}, 32'd1);
    idle();
    chk("mis_update_val_hold", {31'd0, update_val}, 32'd1);
    chk("mis_pulse_off", {31'd0, mispredict}, 32'd0);

    // Backpressure and pointer wrap
    do_reset(1);
    for (int i = 0; i < 4; i++) step(1'b1, 32'(i * 4), i[0], 1'b0, 1'b0);
    chk("bp_occ_full", {29'd0, occupancy}, 32'd4);
    chk("bp_fetch_rdy_full", {31'd0, fetch_rdy}, 32'd0);
    step(1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
    chk("bp_occ_reject", {29'd0, occupancy}, 32'd4);
    chk("bp_head_pc", resolve_pc, 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("bp_occ_after_pop", {29'd0, occupancy}, 32'd3);
    chk("bp_fetch_rdy_after_pop", {31'd0, fetch_rdy}, 32'd1);
    chk("bp_next_head", resolve_pc, 32'h4);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b1, i[0]);
    chk("bp_occ_empty", {29'd0, occupancy}, 32'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 32'h10 + 32'(i * 4), ~i[0], 1'b0, 1'b0);
    chk("wrap_head_pc", resolve_pc, 32'h10);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    chk("wrap_occ_empty", {29'd0, occupancy}, 32'd0);

    // Simultaneous push and pop at occupancy 2
    step(1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h104, 1'b0, 1'b0, 1'b0);
    chk("sim_occ_before", {29'd0, occupancy}, 32'd2);
    step(1'b1, 32'h108, 1'b1, 1'b1, 1'b1);
    chk("sim_occ_after", {29'd0, occupancy}, 32'd2);
    chk("sim_update_en", {31'd0, update_en}, 32'd1);
    chk("sim_head_pc", resolve_pc, 32'h104);
    idle();
    chk("sim_single_pulse", {31'd0, update_en}, 32'd0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("sim_tail_pc", resolve_pc, 32'h108);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    idle();

    // Counter saturation
    do_reset(1);
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 32'h300 + 32'(i * 4), 1'b0, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    end
    idle();
    chk("sat_total", {28'd0, total_cnt}, 32'd15);
    chk("sat_mis", {28'd0, mispred_cnt}, 32'd15);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 32'h400, 1'b1, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    end
    idle();
    chk("sat_total_hold", {28'd0, total_cnt}, 32'd15);
    chk("sat_mis_hold", {28'd0, mispred_cnt}, 32'd15);

    // Reset mid-stream, right after a pop with entries still queued
    step(1'b1, 32'h500, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h504, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h508, 1'b1, 1'b1, 1'b1);
    do_reset(1);
    chk_reset_state("midrst");
    idle();
    idle();
    chk("sb_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_update_ctrl.md
Name: branch_update_ctrl

Overview:
- Sits between fetch/execute and the global branch predictor, on the predictor's update side.
- Fetch side: forwards the fetch PC to the predictor and records each issued prediction in an in-order in-flight queue.
- Resolve side: when execute resolves the oldest branch, the block pops it, drives the predictor's update_en/update_val, flags a mispredict and keeps accuracy counters.

Parameters:
- p_depth, 4, in-flight queue entries; power of two, at least 2.
- p_cnt_width, 16, width of the statistics counters.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset (reset==0 resets on the rising edge of clk)
- fetch_val  in  1  fetch presents a branch
- fetch_rdy  out  1  queue can accept
- fetch_pc  in  32  branch PC
- pred_pc  out  32  PC to predictor; combinational copy of fetch_pc
- pred_in  in  1  predictor's prediction for pred_pc
- fetch_pred  out  1  prediction returned to fetch; combinational copy of pred_in
- resolve_val  in  1  execute presents the outcome of the oldest branch
- resolve_rdy  out  1  queue non-empty
- resolve_taken  in  1  actual outcome
- resolve_pc  out  32  PC of queue head (valid when resolve_rdy)
- update_en  out  1  predictor update strobe
- update_val  out  1  outcome to train
- mispredict  out  1  one-cycle pulse, aligned with update_en
- occupancy  out  clog2(p_depth)+1  entries held
- total_cnt  out  p_cnt_width  resolved branches
- mispred_cnt  out  p_cnt_width  mispredicted branches

Behaviour:
- Reset (reset==0 at a clk edge): queue emptied, occupancy=0, update_en=0, update_val=0, mispredict=0, total_cnt=0, mispred_cnt=0.
- Reset overrides all other activity, including a handshake in the same cycle.
- fetch_rdy = (occupancy != p_depth). There is no bypass when full, even if a pop occurs in the same cycle.
- resolve_rdy = (occupancy != 0). Pushing into an empty queue does not make the entry poppable in that cycle.
- Push: on fetch_val && fetch_rdy, entry {fetch_pc, pred_in} is written at the tail at the clock edge.
- Pop: on resolve_val && resolve_rdy, the head is removed.
- Update pipeline stage after a pop, all registered, all valid in the cycle after the handshake:
  - update_en=1;
  - update_val=resolve_taken;
  - mispredict=(head.pred != resolve_taken).
- In any cycle without a pop, update_en=0 and mispredict=0 in the next cycle; update_val holds its last value.
- Simultaneous push and pop: both happen; occupancy is unchanged.
- Pointers are log2(p_depth) bits wide and wrap modulo p_depth. Occupancy is tracked separately.
- Counters: on each pop, total_cnt increments, and mispred_cnt increments when mispredicted. Both saturate at all-ones and never wrap.
- Counters update in the same edge as the update stage, so their new values are visible together with update_en.
- Outputs with resolve_rdy=0 or fetch_val=0: resolve_pc is don't-care when resolve_rdy=0; pred_pc/fetch_pred follow their inputs regardless of fetch_val.

Decomposition:
- Shared package branch_pkg holds:
  - typedef inflight_entry_t {logic [31:0] pc; logic pred;};
  - localparam for the PC width (32).
- Sub-module branch_inflight_fifo: a parameterized synchronous FIFO of inflight_entry_t with val/rdy on both ends and an occupancy output.
- branch_update_ctrl wraps the FIFO and adds the update-stage registers and the counters.

Test Plan:
- Reset: hold reset=0 for 2 cycles while fetch_val=1 and resolve_val=1. Expect occupancy=0, fetch_rdy=1, resolve_rdy=0, update_en=0, total_cnt=0, mispred_cnt=0.
- Correct prediction:
  - Push pc=0x20C with pred_in=0, then resolve_taken=0.
  - Next cycle: update_en=1, update_val=0, mispredict=0, total_cnt=1, mispred_cnt=0.
  - Following cycle: update_en=0.
- Mispredict:
  - Push pc=0x20C with pred_in=0, then resolve_taken=1.
  - Next cycle: update_en=1, update_val=1, mispredict=1, mispred_cnt increments by 1.
- Backpressure (p_depth=4):
  - Push pcs 0x0,0x4,0x8,0xC → occupancy=4, fetch_rdy=0.
  - A 5th fetch_val is not accepted.
  - Pop once → resolve_pc was 0x0, occupancy=3, fetch_rdy=1.
  - Remaining pops return 0x4,0x8,0xC in order, exercising pointer wrap after 4 more pushes.
- Simultaneous push/pop: with occupancy=2, assert fetch_val and resolve_val in one cycle. Expect occupancy stays 2, one update_en pulse, and FIFO order preserved.
- Saturation (p_cnt_width=4):
  - Resolve 17 mispredicted branches → total_cnt=15, mispred_cnt=15.
  - Further pops leave both counters at 15.
  - Assert reset mid-stream → all outputs return to reset values next cycle.
